rom_msg_sequencer: RTL and testbench

Sequences byte-string reads from the registered message ROM (1-cycle read latency, ASCII text) and streams them to the UART transmitter over a valid/ready handshake. A requester supplies a start address and byte count; the block walks the ROM from that address, holds each byte until the transmitter accepts it, and pulses `done` after the last byte. It sits between the system-level message trigger logic and the UART_tx datapath.

---
 rtl/rom_msg_sequencer.sv | 117 +++++++++++
 tb/tb_rom_msg_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rom_msg_sequencer.sv
// Streams a byte string from the registered message ROM to the UART transmitter.
// One byte per FETCH/WAIT/SEND round; each byte is held until tx_ready accepts it.
module rom_msg_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 84,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDR-1:0]  msg_addr,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  output logic [ADDR-1:0]  rd_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [ADDR-1:0]  rd_addr_nxt;
  logic [WIDTH-1:0] tx_data_nxt;
  logic             tx_valid_nxt, busy_nxt, done_nxt;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR-1:0] next_addr(input logic [ADDR-1:0] a);
    if (a == LAST_ADDR) return '0;
    return a + ADDR'(1);
  endfunction

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    rd_addr_nxt   = rd_addr;
    tx_data_nxt   = tx_data;
    tx_valid_nxt  = tx_valid;
    busy_nxt      = busy;
    done_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (msg_len != '0) begin
            rd_addr_nxt   = msg_addr;
            remaining_nxt = msg_len;
            busy_nxt      = 1'b1;
            state_nxt     = FETCH;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FETCH: state_nxt = WAIT;
      WAIT: begin
        tx_data_nxt  = rom_data;
        tx_valid_nxt = 1'b1;
        state_nxt    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          if (remaining == LEN_W'(1)) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - LEN_W'(1);
            rd_addr_nxt   = next_addr(rd_addr);
            state_nxt     = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over a same-cycle acceptance; that byte is treated as unsent.
    if (abort && state != IDLE) begin
      state_nxt     = IDLE;
      remaining_nxt = remaining;
      rd_addr_nxt   = rd_addr;
      tx_data_nxt   = tx_data;
      tx_valid_nxt  = 1'b0;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      rd_addr   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      rd_addr   <= rd_addr_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rom_msg_sequencer.sv
// Directed bench for rom_msg_sequencer with a registered 84-entry ROM model.
module tb_rom_msg_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 84;
  localparam int ADDR  = 7;
  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, tx_ready;
  logic [ADDR-1:0]  msg_addr, rd_addr;
  logic [LEN_W-1:0] msg_len;
  logic [WIDTH-1:0] rom_data, tx_data;
  logic             tx_valid, busy, done;

  logic [WIDTH-1:0] rom [0:DEPTH-1];

  int n_assert = 0;
  int n_fail   = 0;

  rom_msg_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_addr(msg_addr), .msg_len(msg_len),
    .abort(abort), .rd_addr(rd_addr), .rom_data(rom_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM: one-cycle read latency.
  always_ff @(posedge clk) rom_data <= rom[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input int cyc, input logic ev, input logic eb,
                         input logic ed);
    chk($sformatf("%s_valid_c%0d", tag, cyc), 32'(tx_valid), 32'(ev));
    chk($sformatf("%s_busy_c%0d", tag, cyc), 32'(busy), 32'(eb));
    chk($sformatf("%s_done_c%0d", tag, cyc), 32'(done), 32'(ed));
  endtask

  logic [7:0] nti [0:3];

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'(i + 128);
    rom[0] = 8'h4E; rom[1] = 8'h54; rom[2] = 8'h49; rom[3] = 8'h20;
    nti[0] = 8'h4E; nti[1] = 8'h54; nti[2] = 8'h49; nti[3] = 8'h20;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    msg_addr = '0; msg_len = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    // Basic "NTI " message, tx_ready tied high: bytes at cycles 3,6,9,12, done at 13.
    start = 1'b1; msg_addr = 7'd0; msg_len = 7'd4;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 1) chk("t1_rd_addr_c1", 32'(rd_addr), 32'd0);
      chk_ctl("t1", cyc, (cyc % 3 == 0) && cyc <= 12, cyc <= 12, cyc == 13);
      if ((cyc % 3 == 0) && cyc <= 12)
        chk($sformatf("t1_data_c%0d", cyc), 32'(tx_data), 32'(nti[cyc/3-1]));
    end

    // Back-pressure: tx_ready low in cycles 6..10 holds byte 2 for 6 cycles.
    start = 1'b1; msg_addr = 7'd0; msg_len = 7'd4;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      start = 1'b0;
      tx_ready = !(cyc >= 6 && cyc <= 10);
      chk_ctl("t2", cyc, cyc == 3 || (cyc >= 6 && cyc <= 11) || cyc == 14 || cyc == 17,
              cyc <= 17, cyc == 18);
      if (cyc == 3)               chk($sformatf("t2_data_c%0d", cyc), 32'(tx_data), 32'h4E);
      if (cyc >= 6 && cyc <= 11)  chk($sformatf("t2_data_c%0d", cyc), 32'(tx_data), 32'h54);
      if (cyc == 14)              chk($sformatf("t2_data_c%0d", cyc), 32'(tx_data), 32'h49);
      if (cyc == 17)              chk($sformatf("t2_data_c%0d", cyc), 32'(tx_data), 32'h20);
    end
    tx_ready = 1'b1;

    // Address wrap: 82, 83, 0.
    start = 1'b1; msg_addr = 7'd82; msg_len = 7'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 1) chk("t3_rd_addr_c1", 32'(rd_addr), 32'd82);
      if (cyc == 4) chk("t3_rd_addr_c4", 32'(rd_addr), 32'd83);
      if (cyc == 7) chk("t3_rd_addr_c7", 32'(rd_addr), 32'd0);
      if (cyc == 3) chk("t3_data_c3", 32'(tx_data), 32'hD2);
      if (cyc == 6) chk("t3_data_c6", 32'(tx_data), 32'hD3);
      if (cyc == 9) chk("t3_data_c9", 32'(tx_data), 32'h4E);
      chk_ctl("t3", cyc, cyc == 3 || cyc == 6 || cyc == 9, cyc <= 9, cyc == 10);
    end

    // Zero-length request: done in cycle 1 only, nothing else moves.
    start = 1'b1; msg_addr = 7'd5; msg_len = 7'd0;
    tick();
    start = 1'b0;
    chk_ctl("t4", 1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("t4", 2, 1'b0, 1'b0, 1'b0);

    // Abort during byte-2 SEND with tx_ready high; a restart at cycle 2 is ignored.
    start = 1'b1; msg_addr = 7'd0; msg_len = 7'd4;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      start = (cyc == 2);
      if (cyc == 2) begin msg_addr = 7'd50; msg_len = 7'd1; end
      abort = (cyc == 6);
      if (cyc == 3) chk("t5_data_c3", 32'(tx_data), 32'h4E);
      if (cyc == 4) chk("t5_rd_addr_c4", 32'(rd_addr), 32'd1);
      if (cyc == 6) chk("t5_data_c6", 32'(tx_data), 32'h54);
      chk_ctl("t5", cyc, cyc == 3 || cyc == 6, cyc <= 6, 1'b0);
    end
    start = 1'b0; abort = 1'b0;

    // start+abort together in IDLE: start wins. Then reset mid-message.
    start = 1'b1; abort = 1'b1; msg_addr = 7'd2; msg_len = 7'd4;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      start = 1'b0; abort = 1'b0;
      if (cyc == 1) chk("t6_rd_addr_c1", 32'(rd_addr), 32'd2);
      chk_ctl("t6", cyc, cyc == 3, 1'b1, 1'b0);
    end
    chk("t6_data_c3", 32'(tx_data), 32'h49);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_ctl("t7", 4, 1'b0, 1'b0, 1'b0);
    chk("t7_rd_addr", 32'(rd_addr), 32'd0);
    chk("t7_tx_data", 32'(tx_data), 32'd0);
    tick();
    chk_ctl("t7", 5, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
